uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one UART transmitter between `NUM_REQ` byte producers. It arbitrates among pending requests, latches the winner's byte, and drives the transmitter's start strobe. It then tracks the transmitter's done flag to close the frame, and reports completion or timeout back to the owning requester. It sits between producer logic and the UART transmitter, all in the system clock domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT`, default 20000: system clocks allowed from launch to done rise before abort, ≥ 2.
- `GAP`, default 16: idle system clocks inserted between frames, ≥ 1.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in NUM_REQ: level request per producer. Hold high until `grant` is seen.
- `req_data` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i]. Must be valid while `req[i]` is high.
- `grant` out NUM_REQ: one-hot, one-cycle pulse marking the byte as taken.
- `done` out NUM_REQ: one-hot, one-cycle pulse when the owner's frame completes.
- `err` out 1: one-cycle pulse on timeout abort.
- `busy` out 1: high in every state except IDLE.
- `tx_data_update` out 1: start level to the transmitter.
- `tx_din` out 8: byte to the transmitter. Registered and stable for the whole frame.
- `tx_done` in 1: transmitter done flag. It is produced on the transmitter's divided clock and is treated as asynchronous.

## Operation
- `tx_done` passes through a 2-flop synchronizer to form `done_s`. A registered copy `done_q` gives the rise flag `done_s & ~done_q`.
- Round-robin pointer `ptr`, width clog2(NUM_REQ), resets to 0.
  - Winner = first i with `req[i]=1`, scanning ptr, ptr+1, … modulo NUM_REQ.
  - After each frame ends (completion or abort), `ptr` becomes owner+1 modulo NUM_REQ. With NUM_REQ=4, owner 3 gives ptr 0.
- States:
  - **IDLE**: if `req` ≠ 0, compute the winner w and register all of:
    - `grant[w]`=1 for one cycle;
    - `tx_din`=req_data[w];
    - `owner`=w;
    - `tx_data_update`=1;
    - timer=0;
    - go to WAIT_DONE.
    - If `req`=0, stay in IDLE.
  - **WAIT_DONE**: timer increments every cycle.
    - On the rise flag: `tx_data_update`=0, go to WAIT_CLR.
    - Otherwise, when timer = TIMEOUT-1: `tx_data_update`=0, `err`=1 for one cycle, update `ptr`, go to GUARD. No `done` pulse is issued on abort.
  - **WAIT_CLR**: when `done_s`=0, pulse `done[owner]`=1, update `ptr`, go to GUARD.
  - **GUARD**: count GAP cycles, then go to IDLE.
- `tx_data_update` is held high during WAIT_DONE. It drops within 3 system clocks of `tx_done` rising, so the transmitter cannot re-launch the same byte.
- A requester that drops `req` before being granted is simply not served. There is no penalty and no pointer change.
- Requests arriving outside IDLE wait; only IDLE samples `req`.
- Reset, including mid-frame:
  - all outputs go to 0 immediately (`grant`, `done`, `err`, `busy`, `tx_data_update`, `tx_din`=8'h00);
  - the state goes to IDLE, `ptr`=0, timer=0, and the synchronizer flops are cleared.

## Timing
- Latency:
  - `req` high in IDLE at edge k gives `grant`, `tx_din` and `tx_data_update` valid after edge k.
  - `busy` rises at the same edge.
- Done detection: `tx_done` rise to `tx_data_update` fall is 3 clocks (2 synchronizer stages plus the rise register).
- Completion: `done[owner]` pulses 3 clocks after `tx_done` falls.
- Minimum spacing between consecutive grants: frame duration + 3 + GAP + 1 clocks.
- `grant`, `done` and `err` are never high for more than one consecutive cycle.
- At most one bit of `grant` is ever set, and likewise for `done`. `grant` and `done` are never high in the same cycle.
- Timer width is clog2(TIMEOUT)+1. The timer saturates and does not wrap.

## Test plan
- **Single request**:
  - stimulus: `req`=4'b0100, byte 8'hA5; drive a behavioural transmitter model that raises `tx_done` after 1000 clocks and holds it 100 clocks;
  - response: `grant`=4'b0100 one cycle after the request, `tx_din`=8'hA5, `tx_data_update` low 3 clocks after the `tx_done` rise, `done`=4'b0100 3 clocks after the `tx_done` fall, then ptr=3.
- **Contention**:
  - stimulus: `req`=4'b1111 held, each requester dropping on its own grant;
  - response: grant order 0, 1, 2, 3, separated by ≥ frame + GAP clocks.
- **Wrap-around**:
  - stimulus: after requester 3 is served, assert `req`=4'b1001;
  - response: requester 0 granted first, then requester 3.
- **Timeout**:
  - stimulus: TIMEOUT=50, `tx_done` tied low;
  - response: `err` pulses exactly 50 clocks after the grant, `tx_data_update` falls the same edge, no `done` pulse, ptr advances, and the next request is served after GAP.
- **Reset mid-frame**:
  - stimulus: assert `rst_n`=0 in WAIT_DONE;
  - response: `tx_data_update`, `busy` and `tx_din` are 0 within the same cycle; after release, `req`=4'b0010 is granted from ptr=0 as requester 1.
- **Early withdrawal**:
  - stimulus: `req[2]` pulses for 1 clock while in GUARD;
  - response: no grant to requester 2, and the scheduler returns to IDLE with `busy`=0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART transmitter among NUM_REQ producers
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 20000,
    parameter int GAP     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 busy,
    output logic                 tx_data_update,
    output logic [7:0]           tx_din,
    input  logic                 tx_done
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = $clog2(GAP) + 1;

    localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]      GAP_LAST   = GW'(GAP - 1);
    localparam logic [PW-1:0]      PTR_LAST   = PW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DONE,
        S_WAIT_CLR,
        S_GUARD
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_pls_q, done_pls_d;
    logic                 err_q, err_d;
    logic                 upd_q, upd_d;
    logic [7:0]           din_q, din_d;

    // tx_done comes from the transmitter's divided clock, so resynchronise it
    logic sync1_q, done_s_q, done_q;
    logic done_rise;

    logic [PW-1:0] win;
    logic [7:0]    win_data;
    logic [PW-1:0] ptr_after;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            done_s_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sync1_q  <= tx_done;
            done_s_q <= sync1_q;
            done_q   <= done_s_q;
        end
    end

    assign done_rise = done_s_q & ~done_q;

    // Scan downwards so the requester closest to ptr overwrites the others
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (req[idx]) begin
                win = PW'(idx);
            end
        end
    end

    assign win_data  = req_data[{win, 3'b000} +: 8];
    assign ptr_after = (owner_q == PTR_LAST) ? '0 : owner_q + PW'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        grant_d    = '0;
        done_pls_d = '0;
        err_d      = 1'b0;
        upd_d      = upd_q;
        din_d      = din_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = ONE_HOT0 << win;
                    din_d   = win_data;
                    owner_d = win;
                    upd_d   = 1'b1;
                    timer_d = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
                if (done_rise) begin
                    upd_d   = 1'b0;
                    state_d = S_WAIT_CLR;
                end else if (timer_q == TIMER_LAST) begin
                    upd_d   = 1'b0;
                    err_d   = 1'b1;
                    ptr_d   = ptr_after;
                    gap_d   = '0;
                    state_d = S_GUARD;
                end
            end
            S_WAIT_CLR: begin
                if (!done_s_q) begin
                    done_pls_d = ONE_HOT0 << owner_q;
                    ptr_d      = ptr_after;
                    gap_d      = '0;
                    state_d    = S_GUARD;
                end
            end
            S_GUARD: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            timer_q    <= '0;
            gap_q      <= '0;
            grant_q    <= '0;
            done_pls_q <= '0;
            err_q      <= 1'b0;
            upd_q      <= 1'b0;
            din_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            grant_q    <= grant_d;
            done_pls_q <= done_pls_d;
            err_q      <= err_d;
            upd_q      <= upd_d;
            din_q      <= din_d;
        end
    end

    assign grant          = grant_q;
    assign done           = done_pls_q;
    assign err            = err_q;
    assign busy           = (state_q != S_IDLE);
    assign tx_data_update = upd_q;
    assign tx_din         = din_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant, done;
    logic        err, busy, upd;
    logic [7:0]  tx_din;
    logic        tx_done;

    logic        rst_t;
    logic [3:0]  req_t;
    logic [3:0]  grant_t, done_t;
    logic        err_t, busy_t, upd_t;
    logic [7:0]  din_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int viol     = 0;
    logic [3:0] done_t_acc = '0;
    logic [3:0] grant_prev = '0, done_prev = '0;
    logic       err_prev = 1'b0;

    uart_tx_sched #(.NUM_REQ(4), .TIMEOUT(20000), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .busy(busy),
        .tx_data_update(upd), .tx_din(tx_din), .tx_done(tx_done)
    );

    uart_tx_sched #(.NUM_REQ(4), .TIMEOUT(50), .GAP(GAP)) dut_to (
        .clk(clk), .rst_n(rst_t), .req(req_t), .req_data(32'h0403_0201),
        .grant(grant_t), .done(done_t), .err(err_t), .busy(busy_t),
        .tx_data_update(upd_t), .tx_din(din_t), .tx_done(1'b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ($countones(grant) > 1 || $countones(done) > 1 || (|grant && |done) ||
            (|grant && |grant_prev) || (|done && |done_prev) || (err && err_prev))
            viol = viol + 1;
        grant_prev = grant;
        done_prev  = done;
        err_prev   = err;
        done_t_acc = done_t_acc | done_t;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits for a grant, plays a transmitter frame of f clocks low then h clocks high
    task automatic serve_frame(input logic [3:0] exp, input logic [7:0] exp_byte,
                               input int f, input int h, output int gcyc, output int gwait);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (grant == 4'b0 && n < 400);
        gwait = n;
        gcyc  = cyc;
        check("grant", grant, exp);
        check("tx_din", tx_din, exp_byte);
        check("upd_on", upd, 1'b1);
        check("busy_on", busy, 1'b1);
        req = req & ~exp;
        repeat (f) @(negedge clk);
        tx_done = 1'b1;
        repeat (2) @(negedge clk);
        check("upd_hold", upd, 1'b1);
        @(negedge clk);
        check("upd_fall", upd, 1'b0);
        repeat (h - 3) @(negedge clk);
        tx_done = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (done == 4'b0 && n < 20);
        check("done", done, exp);
        check("done_lat", n, 3);
    endtask

    initial begin
        int g0, g1, g2, g3, w, n;
        logic [3:0] acc;
        rst_n = 1'b0; rst_t = 1'b0; tx_done = 1'b0;
        req = '0; req_t = '0;
        req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 4'b0);
        check("rst_done", done, 4'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_upd", upd, 1'b0);
        check("rst_din", tx_din, 8'h00);
        rst_n = 1'b1; rst_t = 1'b1;
        repeat (2) @(negedge clk);

        // single request
        req = 4'b0100;
        serve_frame(4'b0100, 8'hA5, 1000, 100, g0, w);
        check("single_lat", w, 1);
        check("ptr_after2", dut.ptr_q, 3);
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        check("gap_len", n, GAP);

        // contention from a fresh pointer
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("ptr_reset", dut.ptr_q, 0);
        req = 4'b1111;
        serve_frame(4'b0001, 8'h11, 20, 5, g0, w);
        serve_frame(4'b0010, 8'h22, 20, 5, g1, w);
        serve_frame(4'b0100, 8'hA5, 20, 5, g2, w);
        serve_frame(4'b1000, 8'h44, 20, 5, g3, w);
        check("space01", g1 - g0, 20 + 5 + GAP + 4);
        check("space12", g2 - g1, 20 + 5 + GAP + 4);
        check("space23", g3 - g2, 20 + 5 + GAP + 4);

        // wrap-around
        req = 4'b1001;
        serve_frame(4'b0001, 8'h11, 10, 4, g0, w);
        serve_frame(4'b1000, 8'h44, 10, 4, g1, w);

        // early withdrawal while in GUARD
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        acc = '0;
        repeat (40) begin @(negedge clk); acc = acc | grant; end
        check("withdraw_grant", acc, 4'b0);
        check("withdraw_idle", busy, 1'b0);

        // timeout on the short-timeout instance
        req_t = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (grant_t == 4'b0 && n < 100);
        check("to_grant", grant_t, 4'b0001);
        req_t = 4'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!err_t && n < 100);
        check("to_lat", n, 50);
        check("to_err", err_t, 1'b1);
        check("to_upd", upd_t, 1'b0);
        check("to_ptr", dut_to.ptr_q, 1);
        req_t = 4'b0001;
        @(negedge clk);
        check("to_err_pulse", err_t, 1'b0);
        n = 1;
        do begin @(negedge clk); n++; end while (grant_t == 4'b0 && n < 100);
        check("to_next_lat", n, GAP + 1);
        check("to_next_grant", grant_t, 4'b0001);
        req_t = 4'b0;
        check("to_no_done", done_t_acc, 4'b0);

        // reset mid-frame
        req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (grant == 4'b0 && n < 100);
        req = 4'b0;
        repeat (10) @(negedge clk);
        check("mid_upd_pre", upd, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_upd", upd, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_din", tx_din, 8'h00);
        @(negedge clk);
        check("mid_ptr", dut.ptr_q, 0);
        rst_n = 1'b1;
        @(negedge clk);
        req = 4'b0010;
        n = 0;
        do begin @(negedge clk); n++; end while (grant == 4'b0 && n < 100);
        check("mid_regrant", grant, 4'b0010);
        check("mid_regrant_lat", n, 1);
        req = 4'b0;
        repeat (5) @(negedge clk);

        check("pulse_rules", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
